// File: rtl/dnn_pkg.sv
// Shared constants, data word and loader state type for the DNN classifier front end.
package dnn_pkg;

   localparam int INPUT_SIZE = 784;
   localparam int PIXEL_W    = 8;
   localparam int FRAC_BITS  = 8;
   localparam int DATA_W     = 16;
   localparam int CNT_W      = $clog2(INPUT_SIZE);

   typedef logic signed [DATA_W-1:0] data_t;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_SETTLE,
      ST_RESULT
   } loader_state_t;

endpackage

// File: rtl/pixel_to_fixed.sv
// Unsigned pixel to non-negative signed fixed point: zero-extend, then left-align
// the pixel's binary point with the FRAC_BITS binary point.
module pixel_to_fixed
   import dnn_pkg::DATA_W, dnn_pkg::data_t;
#(
   parameter int PIXEL_W   = 8,
   parameter int FRAC_BITS = 8
) (
   input  logic [PIXEL_W-1:0] i_pix,
   output data_t              o_fixed
);

   localparam int SHIFT = FRAC_BITS - PIXEL_W;

   logic [DATA_W-1:0] w_ext;

   assign w_ext   = {{(DATA_W-PIXEL_W){1'b0}}, i_pix};
   // FRAC_BITS <= 15 keeps the sign bit clear, so the result is always non-negative
   assign o_fixed = data_t'(w_ext << SHIFT);

endmodule

// File: rtl/image_loader.sv
// Image loader: buffers one serial pixel frame, launches the classifier core,
// and hands the resulting digit downstream.
// Optional build macro LOADER_FRAME_CHECK_EN adds pix_last checking, frame_err and
// an internal saturating error counter; without it pix_last is ignored.
//
// state     | meaning
// ST_LOAD   | accepting pixels into the frame buffer
// ST_START  | one-cycle start pulse to the core
// ST_WAIT   | waiting for a fresh rising edge of dnn_done
// ST_SETTLE | one cycle for the core's registered argmax to settle
// ST_RESULT | digit offered downstream until out_ready
module image_loader
   import dnn_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pix_valid,
   input  logic [PIXEL_W-1:0] pix_data,
   input  logic               pix_last,
   output logic               pix_ready,
   output data_t              input_vector [INPUT_SIZE],
   output logic               start,
   input  logic               dnn_done,
   input  logic [3:0]         dnn_digit,
   output logic               out_valid,
   output logic [3:0]         out_digit,
   input  logic               out_ready,
   output logic               busy,
   output logic               frame_err
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_SIZE - 1);

   loader_state_t    r_state;
   logic [CNT_W-1:0] r_cnt;
   data_t            r_buf [INPUT_SIZE];
   logic             r_done_q;
   logic             r_start;
   logic             r_out_valid;
   logic [3:0]       r_out_digit;

   data_t            w_pix_fixed;
   logic             w_accept;
   logic             w_last_slot;
   logic             w_short_frame;

   pixel_to_fixed #(
      .PIXEL_W   (PIXEL_W),
      .FRAC_BITS (FRAC_BITS)
   ) u_conv (
      .i_pix   (pix_data),
      .o_fixed (w_pix_fixed)
   );

   assign w_accept    = pix_valid && (r_state == ST_LOAD);
   assign w_last_slot = (r_cnt == LAST_IDX);

`ifdef LOADER_FRAME_CHECK_EN
   logic       r_frame_err;
   logic [7:0] r_err_cnt;
   logic       w_err;

   assign w_short_frame = pix_last && !w_last_slot;
   // A frame is malformed when pix_last disagrees with the final buffer slot
   assign w_err         = w_accept && (pix_last != w_last_slot);

   // Error pulse and saturating error count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frame_err <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_frame_err <= w_err;
         if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign frame_err = r_frame_err;
`else
   logic w_unused;

   assign w_unused      = pix_last;
   assign w_short_frame = 1'b0;
   assign frame_err     = 1'b0;
`endif

   // Frame buffer: cleared by reset, one element written per accepted pixel
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_buf <= '{default: '0};
      end else if (w_accept) begin
         r_buf[r_cnt] <= w_pix_fixed;
      end
   end

   // Sequencing FSM with registered start/result outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_LOAD;
         r_cnt       <= '0;
         r_done_q    <= 1'b0;
         r_start     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_digit <= '0;
      end else begin
         // done_q tracks dnn_done in every state so a level left high from the
         // previous frame is not mistaken for a new edge on entry to WAIT
         r_done_q <= dnn_done;
         r_start  <= 1'b0;
         case (r_state)
            ST_LOAD: begin
               if (w_accept) begin
                  if (w_last_slot) begin
                     r_cnt   <= '0;
                     r_start <= 1'b1;
                     r_state <= ST_START;
                  end else if (w_short_frame) begin
                     r_cnt   <= '0;
                  end else begin
                     r_cnt   <= r_cnt + 1'b1;
                  end
               end
            end
            ST_START: r_state <= ST_WAIT;
            ST_WAIT: begin
               if (dnn_done && !r_done_q) r_state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               r_out_digit <= dnn_digit;
               r_out_valid <= 1'b1;
               r_state     <= ST_RESULT;
            end
            ST_RESULT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_LOAD;
               end
            end
            default: r_state <= ST_LOAD;
         endcase
      end
   end

   assign pix_ready    = (r_state == ST_LOAD);
   assign busy         = (r_state != ST_LOAD);
   assign start        = r_start;
   assign out_valid    = r_out_valid;
   assign out_digit    = r_out_digit;
   assign input_vector = r_buf;

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: per-cycle comparison against a
// behavioural model plus literal spot checks. Honours LOADER_FRAME_CHECK_EN.
module tb_image_loader;
   import dnn_pkg::*;

`ifdef LOADER_FRAME_CHECK_EN
   localparam bit FRAME_CHK = 1'b1;
`else
   localparam bit FRAME_CHK = 1'b0;
`endif

   localparam int P_LOAD = 0, P_START = 1, P_WAIT = 2, P_SETTLE = 3, P_RESULT = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               pix_valid = 1'b0;
   logic [PIXEL_W-1:0] pix_data = '0;
   logic               pix_last = 1'b0;
   logic               pix_ready;
   data_t              input_vector [INPUT_SIZE];
   logic               start;
   logic               dnn_done = 1'b0;
   logic [3:0]         dnn_digit = '0;
   logic               out_valid;
   logic [3:0]         out_digit;
   logic               out_ready = 1'b0;
   logic               busy;
   logic               frame_err;

   image_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pix_valid    (pix_valid),
      .pix_data     (pix_data),
      .pix_last     (pix_last),
      .pix_ready    (pix_ready),
      .input_vector (input_vector),
      .start        (start),
      .dnn_done     (dnn_done),
      .dnn_digit    (dnn_digit),
      .out_valid    (out_valid),
      .out_digit    (out_digit),
      .out_ready    (out_ready),
      .busy         (busy),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic report_timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
   endtask

   // ---------------- behavioural model ----------------
   int exp_vec [INPUT_SIZE];
   int m_cnt = 0;
   int m_phase = P_LOAD;
   bit m_prev_done = 1'b0;
   bit m_acc = 1'b0;
   bit exp_err = 1'b0;
   bit exp_valid = 1'b0;
   int exp_digit = 0;

   // Model advances on each edge from the inputs, then the outputs are compared
   always @(posedge clk) begin : model_and_compare
      int bad;
      m_acc   = 1'b0;
      exp_err = 1'b0;
      if (!rst_n) begin
         foreach (exp_vec[i]) exp_vec[i] = 0;
         m_cnt       = 0;
         m_phase     = P_LOAD;
         exp_valid   = 1'b0;
         exp_digit   = 0;
         m_prev_done = 1'b0;
      end else begin
         case (m_phase)
            P_LOAD: if (pix_valid) begin
               m_acc = 1'b1;
               exp_vec[m_cnt] = int'(pix_data) * (2 ** (FRAC_BITS - PIXEL_W));
               if (m_cnt == INPUT_SIZE - 1) begin
                  m_cnt   = 0;
                  m_phase = P_START;
                  exp_err = FRAME_CHK && !pix_last;
               end else if (FRAME_CHK && pix_last) begin
                  m_cnt   = 0;
                  exp_err = 1'b1;
               end else begin
                  m_cnt++;
               end
            end
            P_START:  m_phase = P_WAIT;
            P_WAIT:   if (dnn_done && !m_prev_done) m_phase = P_SETTLE;
            P_SETTLE: begin
               exp_digit = int'(dnn_digit);
               exp_valid = 1'b1;
               m_phase   = P_RESULT;
            end
            default: if (out_ready) begin
               exp_valid = 1'b0;
               m_phase   = P_LOAD;
            end
         endcase
         m_prev_done = dnn_done;
      end
      #1;
      check("pix_ready", int'(pix_ready), int'(m_phase == P_LOAD));
      check("start",     int'(start),     int'(m_phase == P_START));
      check("busy",      int'(busy),      int'(m_phase != P_LOAD));
      check("out_valid", int'(out_valid), int'(exp_valid));
      check("out_digit", int'(out_digit), exp_digit);
      check("frame_err", int'(frame_err), int'(exp_err));
      bad = -1;
      for (int i = 0; i < INPUT_SIZE; i++)
         if (bad < 0 && int'(input_vector[i]) != exp_vec[i]) bad = i;
      check("input_vector", (bad < 0) ? 0 : int'(input_vector[bad]),
            (bad < 0) ? 0 : exp_vec[bad]);
   end

   // ---------------- stimulus ----------------
   // mode 0: pixel k = k mod 256; mode 1: random data. last_at < 0: no pix_last.
   task automatic send_pixels(input int n, input int mode, input int last_at,
                              input bit gaps, input bit junk_after);
      int k = 0;
      int budget = 0;
      while (k < n && budget < 20000) begin
         @(negedge clk);
         if (gaps && ($urandom_range(1, 0) == 0)) begin
            pix_valid = 1'b0;
            pix_last  = 1'b0;
            pix_data  = 8'($urandom_range(255, 0));
         end else begin
            pix_valid = 1'b1;
            pix_data  = (mode == 0) ? k[7:0] : 8'($urandom_range(255, 0));
            pix_last  = (k == last_at);
         end
         @(posedge clk);
         #2;
         budget++;
         if (m_acc) k++;
      end
      if (k < n) report_timeout("send_pixels");
      @(negedge clk);
      pix_last  = 1'b0;
      pix_valid = junk_after;
      pix_data  = 8'($urandom_range(255, 0));
   endtask

   // Core model: done edge lat cycles after start, digit one cycle later.
   // With prefilled, dnn_done is already high and must drop and rise again.
   task automatic run_core(input int lat, input int digit, input bit prefilled,
                           input bit leave_high);
      int t = 0;
      while (!start && t < 100) begin
         @(posedge clk);
         #3;
         t++;
      end
      if (!start) report_timeout("start");
      repeat (lat) begin
         @(posedge clk);
         #3;
         if (prefilled) check("no_early_valid", int'(out_valid), 0);
      end
      if (prefilled) begin
         @(negedge clk);
         dnn_done = 1'b0;
         repeat (2) @(negedge clk);
      end else begin
         @(negedge clk);
      end
      dnn_done = 1'b1;
      @(posedge clk);
      #3;
      check("valid_settle", int'(out_valid), 0);
      @(negedge clk);
      dnn_digit = 4'(digit);
      @(posedge clk);
      #3;
      check("valid_e2", int'(out_valid), 1);
      check("digit_e2", int'(out_digit), digit);
      @(negedge clk);
      pix_valid = 1'b0;
      dnn_digit = 4'($urandom_range(15, 0));
      repeat (5) begin
         @(posedge clk);
         #3;
         check("hold_valid", int'(out_valid), 1);
         check("hold_digit", int'(out_digit), digit);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #3;
      check("ready_after", int'(pix_ready), 1);
      check("valid_after", int'(out_valid), 0);
      @(negedge clk);
      out_ready = 1'b0;
      if (!leave_high) dnn_done = 1'b0;
   endtask

   initial begin
      int nz;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #3;
      check("rst_ready", int'(pix_ready), 1);
      check("rst_busy", int'(busy), 0);

      // Frame A: k mod 256, no gaps, core latency 20, digit 7; done left high
      send_pixels(INPUT_SIZE, 0, INPUT_SIZE - 1, 1'b0, 1'b1);
      check("a_start", int'(start), 1);
      check("a_ready_low", int'(pix_ready), 0);
      check("a_elem5", int'(input_vector[5]), 5);
      check("a_elem300", int'(input_vector[300]), 44);
      check("a_elem783", int'(input_vector[783]), 15);
      run_core(20, 7, 1'b0, 1'b1);

      // Frame B: random data, dnn_done still high from frame A
      send_pixels(INPUT_SIZE, 1, INPUT_SIZE - 1, 1'b0, 1'b1);
      run_core(10, 3, 1'b1, 1'b0);

      // Frame C: k mod 256 with random gaps; buffer must match gap-free pattern
      send_pixels(INPUT_SIZE, 0, INPUT_SIZE - 1, 1'b1, 1'b1);
      nz = 0;
      for (int i = 0; i < INPUT_SIZE; i++)
         if (int'(input_vector[i]) != (i % 256)) nz++;
      check("c_gap_pattern", nz, 0);
      run_core(5, 9, 1'b0, 1'b0);

      // Reset after 300 pixels of a frame
      send_pixels(300, 1, -1, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      nz = 0;
      for (int i = 0; i < INPUT_SIZE; i++) if (input_vector[i] != 0) nz++;
      check("rst_zero_elems", nz, 0);
      check("rst_mid_ready", int'(pix_ready), 1);

      // Fresh frames with random data, gaps and latencies
      repeat (2) begin
         send_pixels(INPUT_SIZE, 1, INPUT_SIZE - 1, 1'b1, 1'b1);
         run_core($urandom_range(12, 1), $urandom_range(15, 0), 1'b0, 1'b0);
      end

`ifdef LOADER_FRAME_CHECK_EN
      // Short frame: pix_last on pixel 99
      send_pixels(100, 0, 99, 1'b0, 1'b0);
      check("short_err", int'(frame_err), 1);
      check("short_no_start", int'(start), 0);
      check("short_ready", int'(pix_ready), 1);
      send_pixels(INPUT_SIZE, 1, INPUT_SIZE - 1, 1'b0, 1'b1);
      check("after_short_start", int'(start), 1);
      check("after_short_err", int'(frame_err), 0);
      run_core(4, 2, 1'b0, 1'b0);
      // Missing pix_last on final pixel: processed anyway, error flagged
      send_pixels(INPUT_SIZE, 1, -1, 1'b0, 1'b1);
      check("nolast_start", int'(start), 1);
      check("nolast_err", int'(frame_err), 1);
      run_core(4, 11, 1'b0, 1'b0);
`endif

      repeat (3) @(posedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
